modulation_sampler: RTL and testbench

Sequencer that sits directly downstream of the modulation buffer in the CLK domain: it generates the read address ADDR that drives the buffer's port B and captures the returned 8-bit MOD sample. It steps through a modulation sequence of MOD_CYCLE+1 samples, holding each sample for MOD_FREQ_DIV+1 clocks. It compensates for the buffer's read latency and presents a registered, index-tagged sample with a one-cycle valid strobe to the per-transducer duty logic.

---
 rtl/modulation_sampler.sv | 137 +++++++++++++
 tb/tb_modulation_sampler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modulation_sampler.sv
// -----------------------------------------------------------------------------
// modulation_sampler
//
// Steps through a modulation sequence stored in the modulation buffer. The
// sequence has MOD_CYCLE+1 samples, and each sample is held for
// MOD_FREQ_DIV+1 clocks. The block drives the buffer's port-B read address,
// waits out the buffer read latency, and then presents each returned sample
// as a registered value. Each sample carries its sequence index and a
// one-cycle valid strobe.
//
// Handshake: there is no back-pressure. MOD_VALID is a one-cycle strobe
// meaning "MOD_OUT/MOD_IDX took a new value on this edge". The consumer must
// take it in that cycle.
//
// Parameters
//   BRAM_LATENCY  port-B read latency in clock edges, address to data (1..4)
//
// Ports
//   CLK           system clock
//   RST           synchronous active-high reset
//   START         pulse: latch configuration and restart the sequence at 0
//   STOP          pulse: halt sequencing (wins over START)
//   MOD_CYCLE     last sample index
//   MOD_FREQ_DIV  clocks per sample minus 1
//   ADDR          read address to the modulation buffer port B
//   MOD_IN        sample data returned by the buffer
//   MOD_OUT       registered current sample
//   MOD_VALID     one-cycle strobe when MOD_OUT updates
//   MOD_IDX       sequence index of the sample on MOD_OUT
//   BUSY          high while sequencing (state == RUN)
// -----------------------------------------------------------------------------
module modulation_sampler #(
  parameter int BRAM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic [15:0] MOD_CYCLE,
  input  logic [15:0] MOD_FREQ_DIV,
  output logic [15:0] ADDR,
  input  logic [7:0]  MOD_IN,
  output logic [7:0]  MOD_OUT,
  output logic        MOD_VALID,
  output logic [15:0] MOD_IDX,
  output logic        BUSY
);

  // One stage per latency edge, plus the capture edge.
  localparam int PL = BRAM_LATENCY + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [15:0] cycle_s;
  logic [15:0] div_s;
  logic [15:0] idx;
  logic [15:0] div_cnt;
  logic [PL-1:0] flag_pipe;
  logic [15:0] idx_pipe [PL];

  logic        wrap;
  logic [15:0] next_idx;
  logic        flush;

  always_comb begin
    wrap     = (idx == cycle_s);
    next_idx = wrap ? 16'd0 : idx + 16'd1;
    // START or STOP discards every read in flight, including one that
    // would have been captured on this very edge.
    flush    = START | STOP;
  end

  assign BUSY = (state == RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cycle_s   <= '0;
      div_s     <= '0;
      idx       <= '0;
      div_cnt   <= '0;
      ADDR      <= '0;
      flag_pipe <= '0;
      for (int i = 0; i < PL; i++) idx_pipe[i] <= '0;
      MOD_OUT   <= '0;
      MOD_VALID <= 1'b0;
      MOD_IDX   <= '0;
    end else begin
      // Read pipeline. By default it shifts, and no new read is issued.
      flag_pipe   <= {flag_pipe[PL-2:0], 1'b0};
      idx_pipe[0] <= idx;
      for (int i = 1; i < PL; i++) idx_pipe[i] <= idx_pipe[i-1];

      // Capture a sample whose read has reached the end of the pipeline.
      if (flag_pipe[PL-1] && !flush) begin
        MOD_OUT   <= MOD_IN;
        MOD_IDX   <= idx_pipe[PL-1];
        MOD_VALID <= 1'b1;
      end else begin
        MOD_VALID <= 1'b0;
      end

      if (STOP) begin
        // ADDR, MOD_OUT and MOD_IDX hold their values. No reload happens.
        state     <= IDLE;
        flag_pipe <= '0;
      end else if (START) begin
        state       <= RUN;
        cycle_s     <= MOD_CYCLE;
        div_s       <= MOD_FREQ_DIV;
        idx         <= '0;
        div_cnt     <= '0;
        ADDR        <= '0;
        flag_pipe   <= {{(PL-1){1'b0}}, 1'b1};
        idx_pipe[0] <= '0;
      end else if (state == RUN) begin
        if (div_cnt == div_s) begin
          div_cnt <= '0;
          // The shadow registers reload only when the sequence wraps, so
          // the sequence in progress keeps its configuration.
          if (wrap) begin
            cycle_s <= MOD_CYCLE;
            div_s   <= MOD_FREQ_DIV;
          end
          idx          <= next_idx;
          ADDR         <= next_idx;
          flag_pipe[0] <= 1'b1;
          idx_pipe[0]  <= next_idx;
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_modulation_sampler.sv
// -----------------------------------------------------------------------------
// tb_modulation_sampler
//
// Directed bench for modulation_sampler. It builds three DUT instances that
// share the same stimulus: BRAM_LATENCY 2 (main), 1 and 4. Each instance has
// its own buffer model holding MOD[i] = i + 0x10. The model has a read
// latency that matches its instance.
// -----------------------------------------------------------------------------
module tb_modulation_sampler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] mod_cycle;
  logic [15:0] mod_freq_div;

  logic [2:0][15:0] addr_v;
  logic [2:0][7:0]  out_v;
  logic [2:0]       valid_v;
  logic [2:0][15:0] idx_v;
  logic [2:0]       busy_v;

  int vectors;
  int miscompares;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs + buffer models ----------------
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [15:0] addr;
    logic [7:0]  mod_in;
    logic [7:0]  mod_out;
    logic        mod_valid;
    logic [15:0] mod_idx;
    logic        busy;
    logic [7:0]  rd_pipe [LAT];

    // Buffer port B: the data for an address appears LAT edges later.
    always @(posedge clk) begin
      rd_pipe[0] <= addr[7:0] + 8'h10;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mod_in = rd_pipe[LAT-1];

    modulation_sampler #(.BRAM_LATENCY(LAT)) dut (
      .CLK          (clk),
      .RST          (rst),
      .START        (start),
      .STOP         (stop),
      .MOD_CYCLE    (mod_cycle),
      .MOD_FREQ_DIV (mod_freq_div),
      .ADDR         (addr),
      .MOD_IN       (mod_in),
      .MOD_OUT      (mod_out),
      .MOD_VALID    (mod_valid),
      .MOD_IDX      (mod_idx),
      .BUSY         (busy)
    );

    assign addr_v[g]  = addr;
    assign out_v[g]   = mod_out;
    assign valid_v[g] = mod_valid;
    assign idx_v[g]   = mod_idx;
    assign busy_v[g]  = busy;
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the edge that sampled START.
  task automatic start_seq(input logic [15:0] cyc, input logic [15:0] div);
    mod_cycle    = cyc;
    mod_freq_div = div;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int  lat;
  int  ev;
  int  k;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    mod_cycle    = '0;
    mod_freq_div = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_addr",  addr_v[0], 16'd0);
    chk("rst_out",   16'(out_v[0]), 16'd0);
    chk("rst_valid", 16'(valid_v[0]), 16'd0);
    chk("rst_idx",   idx_v[0], 16'd0);
    chk("rst_busy",  16'(busy_v[0]), 16'd0);

    // Scenario 1: cycle 3, div 4 on all three latencies
    start_seq(16'd3, 16'd4);
    chk("s1_addr0",  addr_v[0], 16'd0);
    chk("s1_busy",   16'(busy_v[0]), 16'd1);
    chk("s1_valid0", 16'(valid_v[0]), 16'd0);
    for (int t = 1; t <= 28; t++) begin
      tick();
      chk("s1_addr", addr_v[0], 16'((t / 5) % 4));
      for (int g = 0; g < 3; g++) begin
        lat = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        ev  = ((t >= lat + 1) && (((t - lat - 1) % 5) == 0)) ? 1 : 0;
        chk("s1_valid", 16'(valid_v[g]), 16'(ev));
        if (t >= lat + 1)
          chk("s1_out", 16'(out_v[g]), 16'(16 + ((t - lat - 1) / 5) % 4));
      end
    end

    // STOP mid-sequence: outputs hold, no more strobes
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy",  16'(busy_v[0]), 16'd0);
    chk("stop_valid", 16'(valid_v[0]), 16'd0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk("stop_valid_hold", 16'(valid_v[0]), 16'd0);
    end
    chk("stop_out_hold",  16'(out_v[0]), 16'h11);
    chk("stop_idx_hold",  idx_v[0], 16'd1);
    chk("stop_addr_hold", addr_v[0], 16'd1);

    // Scenario 2: cycle 0, div 0
    start_seq(16'd0, 16'd0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk("s2_addr",  addr_v[0], 16'd0);
      chk("s2_valid", 16'(valid_v[0]), (t >= 3) ? 16'd1 : 16'd0);
      if (t >= 3) begin
        chk("s2_idx", idx_v[0], 16'd0);
        chk("s2_out", 16'(out_v[0]), 16'h10);
      end
    end

    // Restart with reads in flight
    start_seq(16'd7, 16'd0);
    for (int t = 1; t <= 5; t++) tick();
    chk("rs_addr5",  addr_v[0], 16'd5);
    chk("rs_valid5", 16'(valid_v[0]), 16'd1);
    chk("rs_idx5",   idx_v[0], 16'd2);
    start_seq(16'd7, 16'd0);
    chk("rs_addr0",  addr_v[0], 16'd0);
    chk("rs_flush0", 16'(valid_v[0]), 16'd0);
    chk("rs_idx_hold0", idx_v[0], 16'd2);
    tick();
    chk("rs_flush1", 16'(valid_v[0]), 16'd0);
    tick();
    chk("rs_flush2", 16'(valid_v[0]), 16'd0);
    chk("rs_idx_hold2", idx_v[0], 16'd2);
    tick();
    chk("rs_valid3", 16'(valid_v[0]), 16'd1);
    chk("rs_idx3",   idx_v[0], 16'd0);
    chk("rs_out3",   16'(out_v[0]), 16'h10);
    tick();
    chk("rs_idx4",   idx_v[0], 16'd1);
    chk("rs_addr4",  addr_v[0], 16'd4);

    // START and STOP together: STOP wins
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy",  16'(busy_v[0]), 16'd0);
    chk("ss_valid", 16'(valid_v[0]), 16'd0);
    chk("ss_addr",  addr_v[0], 16'd4);
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk("ss_valid_hold", 16'(valid_v[0]), 16'd0);
      chk("ss_addr_hold",  addr_v[0], 16'd4);
    end

    // Shadow reload: div changes 4 -> 1 at index 2, takes effect at the wrap
    start_seq(16'd7, 16'd4);
    for (int t = 1; t <= 48; t++) begin
      tick();
      if (t == 10) begin
        chk("sh_addr2", addr_v[0], 16'd2);
        mod_freq_div = 16'd1;
      end
      if (t >= 3 && t <= 38 && ((t - 3) % 5) == 0) begin
        ev = 1; k = (t - 3) / 5;
      end else if (t >= 43 && ((t - 43) % 2) == 0) begin
        ev = 1; k = (t - 43) / 2;
      end else begin
        ev = 0; k = 0;
      end
      chk("sh_valid", 16'(valid_v[0]), 16'(ev));
      if (ev == 1) begin
        chk("sh_idx", idx_v[0], 16'(k));
        chk("sh_out", 16'(out_v[0]), 16'(16 + k));
      end
    end
    chk("sh_addr48", addr_v[0], 16'd4);

    // Reset mid-RUN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_addr",  addr_v[0], 16'd0);
    chk("mr_out",   16'(out_v[0]), 16'd0);
    chk("mr_valid", 16'(valid_v[0]), 16'd0);
    chk("mr_idx",   idx_v[0], 16'd0);
    chk("mr_busy",  16'(busy_v[0]), 16'd0);
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("mr_idle_busy",  16'(busy_v[0]), 16'd0);
      chk("mr_idle_valid", 16'(valid_v[0]), 16'd0);
      chk("mr_idle_addr",  addr_v[0], 16'd0);
    end
    start_seq(16'd3, 16'd4);
    chk("mr_busy_again", 16'(busy_v[0]), 16'd1);
    tick();
    tick();
    chk("mr_valid2", 16'(valid_v[0]), 16'd0);
    tick();
    chk("mr_valid3", 16'(valid_v[0]), 16'd1);
    chk("mr_out3",   16'(out_v[0]), 16'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
